// File: rtl/dot_product_pkg.sv
// rtl/dot_product_pkg.sv - shared types and width helpers for the dot-product MAC
//
// Purpose: holds the two-state FSM encoding and the function that sizes the
// accumulator so that a full K-term dot product can never overflow.
// Ports: none (package).
package dot_product_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  // Each product needs 2*dw bits. Summing k of them adds up to clog2(k) carry bits.
  function automatic int calc_rw(input int dw, input int k);
    return 2 * dw + $clog2(k);
  endfunction

endpackage

// File: rtl/dot_mac_step.sv
// rtl/dot_mac_step.sv - combinational RW-bit multiply-add, sum = acc + a*b
//
// Purpose: one accumulation step of the dot product. Operands are widened to
// RW before multiplying, so the RW-bit product is exact.
// Configuration: DOT_PRODUCT_SIGNED_EN selects two's-complement elements
// (sign-extended); when it is undefined, elements are unsigned (zero-extended).
// Ports:
//   acc  input  RW  running accumulator
//   a    input  DW  row element
//   b    input  DW  column element
//   sum  output RW  acc + a*b
module dot_mac_step #(
  parameter int DW = 8,
  parameter int RW = 18
) (
  input  logic [RW-1:0] acc,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [RW-1:0] sum
);

  logic [RW-1:0] a_ext;
  logic [RW-1:0] b_ext;

`ifdef DOT_PRODUCT_SIGNED_EN
  // The low RW bits of the product of two sign-extended values equal the true
  // signed product, because |a*b| fits in 2*DW bits and 2*DW < RW.
  assign a_ext = {{(RW-DW){a[DW-1]}}, a};
  assign b_ext = {{(RW-DW){b[DW-1]}}, b};
`else
  assign a_ext = {{(RW-DW){1'b0}}, a};
  assign b_ext = {{(RW-DW){1'b0}}, b};
`endif

  assign sum = acc + a_ext * b_ext;

endmodule

// File: rtl/dot_product_mac.sv
// rtl/dot_product_mac.sv - sequential K-element dot-product multiply-accumulate
//
// Purpose: captures two K-element vectors on start. It then accumulates one
// product per cycle and, after K cycles, presents the sum on result with a
// one-cycle done pulse.
// Configuration: DOT_PRODUCT_SIGNED_EN selects signed elements and a signed
// result. The default build (macro undefined) treats elements as unsigned.
// Ports:
//   clk     input  1     clock, rising edge
//   reset   input  1     synchronous, active-high reset
//   start   input  1     begin one dot product (accepted only in IDLE)
//   a_vec   input  K*DW  row operand, element i at [i*DW +: DW]
//   b_vec   input  K*DW  column operand, same packing
//   result  output RW    last completed dot product, held between done pulses
//   done    output 1     one-cycle pulse when result updates
//   busy    output 1     high while accumulating
module dot_product_mac
  import dot_product_pkg::*;
#(
  parameter int DW = 8,
  parameter int K  = 4,
  parameter int RW = calc_rw(DW, K)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [K*DW-1:0]    a_vec,
  input  logic [K*DW-1:0]    b_vec,
`ifdef DOT_PRODUCT_SIGNED_EN
  output logic signed [RW-1:0] result,
`else
  output logic [RW-1:0]      result,
`endif
  output logic               done,
  output logic               busy
);

  localparam int IW = $clog2(K);
  localparam logic [IW-1:0] LAST_IDX = IW'(K - 1);

  if (RW < calc_rw(DW, K)) begin : g_rw_check
    $error("dot_product_mac: RW too small for a lossless K-term sum");
  end

  state_t          state;
  state_t          state_next;
  logic [K*DW-1:0] a_reg;
  logic [K*DW-1:0] b_reg;
  logic [RW-1:0]   acc;
  logic [IW-1:0]   index;
  logic [RW-1:0]   step_sum;
  logic            last_step;

  dot_mac_step #(
    .DW (DW),
    .RW (RW)
  ) u_step (
    .acc (acc),
    .a   (a_reg[index*DW +: DW]),
    .b   (b_reg[index*DW +: DW]),
    .sum (step_sum)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)     state_next = ACC;
      ACC:     if (last_step) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Output / decode logic
  always_comb begin
    busy      = 1'b0;
    last_step = 1'b0;
    if (state == ACC) begin
      busy      = 1'b1;
      last_step = (index == LAST_IDX);
    end
  end

  // Operand capture. These registers have no reset: they are loaded on every
  // accepted start and are read only while in ACC.
  always_ff @(posedge clk) begin
    if (!reset && state == IDLE && start) begin
      a_reg <= a_vec;
      b_reg <= b_vec;
    end
  end

  // Accumulator, index, result and done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= '0;
      index  <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          acc   <= '0;
          index <= '0;
        end
      end else begin
        acc   <= step_sum;
        index <= index + IW'(1);
        if (last_step) begin
          result <= step_sum;
          done   <= 1'b1;
          index  <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dot_product_mac.sv
// tb/tb_dot_product_mac.sv - self-checking bench for dot_product_mac against a reference model
module tb_dot_product_mac;

  localparam int DW = 8;
  localparam int K  = 4;
  localparam int RW = 2 * DW + $clog2(K);

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [K*DW-1:0] a_vec;
  logic [K*DW-1:0] b_vec;
  logic [RW-1:0]   result;
  logic            done;
  logic            busy;

  int checks   = 0;
  int failures = 0;

  dot_product_mac #(
    .DW (DW),
    .K  (K),
    .RW (RW)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a_vec  (a_vec),
    .b_vec  (b_vec),
    .result (result),
    .done   (done),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: the plain sum of element products, truncated to RW bits.
  function automatic logic [RW-1:0] model(input logic [K*DW-1:0] a, input logic [K*DW-1:0] b);
    longint s = 0;
    logic [DW-1:0] ea;
    logic [DW-1:0] eb;
    for (int i = 0; i < K; i++) begin
      ea = a[i*DW +: DW];
      eb = b[i*DW +: DW];
`ifdef DOT_PRODUCT_SIGNED_EN
      s += longint'($signed(ea)) * longint'($signed(eb));
`else
      s += longint'(ea) * longint'(eb);
`endif
    end
    return s[RW-1:0];
  endfunction

  function automatic logic [K*DW-1:0] pack(input int e0, input int e1, input int e2, input int e3);
    logic [K*DW-1:0] v;
    v = {DW'(e3), DW'(e2), DW'(e1), DW'(e0)};
    return v;
  endfunction

  // One operation with a fixed latency. After the start edge, busy is high
  // for K cycles. done then rises in the cycle after edge t+K.
  task automatic do_op(input string tag, input logic [K*DW-1:0] a, input logic [K*DW-1:0] b,
                       input bit zero_after, input logic [RW-1:0] exp);
    @(negedge clk);
    a_vec = a;
    b_vec = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (zero_after) begin
      a_vec = '0;
      b_vec = '0;
    end
    for (int i = 0; i < K; i++) begin
      @(negedge clk);
      check({tag, "_busy"}, 64'(busy), 64'd1);
      check({tag, "_nodone"}, 64'(done), 64'd0);
      if (i == 1) start = 1'b1;  // ignored while busy
      if (i == 2) start = 1'b0;
    end
    @(negedge clk);
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_busy_in_done"}, 64'(busy), 64'd0);
    check({tag, "_result"}, 64'(result), 64'(exp));
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_idle"}, 64'(busy), 64'd0);
    check({tag, "_hold"}, 64'(result), 64'(exp));
  endtask

  logic [K*DW-1:0] va;
  logic [K*DW-1:0] vb;
  logic [K*DW-1:0] sets_a[4];
  logic [K*DW-1:0] sets_b[4];
  logic [RW-1:0]   last_res;
  int              done_seen;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    a_vec = '0;
    b_vec = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_result", 64'(result), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);

    // Directed cases: the known 70, then the same vectors zeroed one cycle after start.
    va = pack(1, 2, 3, 4);
    vb = pack(5, 6, 7, 8);
`ifndef DOT_PRODUCT_SIGNED_EN
    check("const_70", 64'(model(va, vb)), 64'd70);
`endif
    do_op("basic", va, vb, 1'b0, model(va, vb));
    do_op("capture", va, vb, 1'b1, model(va, vb));

`ifdef DOT_PRODUCT_SIGNED_EN
    va = {K{8'hFF}};
    vb = {K{8'h01}};
    do_op("neg4", va, vb, 1'b0, 18'h3FFFC);
    va = {K{8'h80}};
    vb = {K{8'h80}};
    do_op("maxpos", va, vb, 1'b0, model(va, vb));
`else
    va = {K{8'hFF}};
    vb = {K{8'hFF}};
    do_op("all_ff", va, vb, 1'b0, 18'h3F804);
`endif

    // Randomized operations
    for (int n = 0; n < 20; n++) begin
      va = {$urandom, $urandom};
      vb = {$urandom, $urandom};
      do_op("rand", va, vb, n[0], model(va, vb));
    end

    // Back-to-back operations with start held high. Garbage driven while busy
    // must not be captured, and done must recur every K+1 cycles.
    for (int s = 0; s < 4; s++) begin
      sets_a[s] = {$urandom, $urandom};
      sets_b[s] = {$urandom, $urandom};
    end
    @(negedge clk);
    start = 1'b1;
    a_vec = sets_a[0];
    b_vec = sets_b[0];
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < K; c++) begin
        @(negedge clk);
        check("b2b_nodone", 64'(done), 64'd0);
        check("b2b_busy", 64'(busy), 64'd1);
        a_vec = {$urandom, $urandom};
        b_vec = {$urandom, $urandom};
      end
      @(negedge clk);
      check("b2b_done", 64'(done), 64'd1);
      check("b2b_result", 64'(result), 64'(model(sets_a[s], sets_b[s])));
      a_vec = sets_a[(s + 1) % 4];
      b_vec = sets_b[(s + 1) % 4];
    end
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("b2b_stop", 64'(busy), 64'd0);

    // Reset at edge t+2 aborts the operation, and no done follows.
    va = pack(9, 10, 11, 12);
    vb = pack(3, 3, 3, 3);
    @(negedge clk);
    a_vec = va;
    b_vec = vb;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_result", 64'(result), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    done_seen = 0;
    for (int c = 0; c < K + 2; c++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("abort_no_done", 64'(done_seen), 64'd0);
    do_op("after_abort", va, vb, 1'b0, model(va, vb));

    // result holds while idle and inputs wiggle
    last_res = result;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      a_vec = {$urandom, $urandom};
      check("idle_hold", 64'(result), 64'(last_res));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dot_product_mac.md
DOT_PRODUCT_MAC -- requirements
Module: dot_product_mac

Interface
REQ-001 Parameter: DW, default 8, element width in bits.
REQ-002 Parameter: K, default 4, vector length (elements per operand), K >= 2.
REQ-003 Parameter: RW, default 2*DW+$clog2(K), result width; RW shall never be overridden below this value.
REQ-004 Port: clk  input  1  clock; all state changes on the rising edge.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: start  input  1  request to compute one dot product; sampled only in IDLE.
REQ-007 Port: a_vec  input  K*DW  row operand; element i at bits [i*DW +: DW].
REQ-008 Port: b_vec  input  K*DW  column operand; same packing as a_vec.
REQ-009 Port: result  output  RW  last completed dot product; drives the downstream register-stage data input.
REQ-010 Port: done  output  1  one-cycle pulse, result valid; drives the downstream register-stage start input.
REQ-011 Port: busy  output  1  high while a computation is in progress.

Function
REQ-012 The FSM shall have exactly two states: IDLE and ACC.
REQ-013 In IDLE with start=1 at an edge, the block shall capture a_vec and b_vec into internal registers, clear the accumulator, set index=0, and move to ACC.
REQ-014 Operands shall not be re-sampled after capture; input changes during ACC shall not affect the result.
REQ-015 In ACC, each edge shall add a[index]*b[index] to the accumulator and increment index.
REQ-016 On the ACC edge with index==K-1, result shall load accumulator+final product, done shall be set, and the FSM shall return to IDLE.
REQ-017 Latency: start sampled at edge t -> done high in the cycle after edge t+K, for exactly one cycle.
REQ-018 busy shall be high in the cycles after edges t..t+K-1 and low otherwise, including the done cycle.
REQ-019 start while busy=1 shall be ignored, with no queuing.
REQ-020 start=1 during the done cycle shall be accepted, allowing back-to-back operations every K+1 cycles.
REQ-021 result shall hold its value between done pulses and change only on the edge that asserts done.
REQ-022 Products and the accumulator shall be RW bits wide, and no overflow shall be possible for any input.

Reset
REQ-023 reset=1 at an edge shall force IDLE, result=0, done=0, busy=0, index=0 and accumulator=0.
REQ-024 reset shall take priority over start and over an in-progress ACC; an aborted operation shall never produce done.
REQ-025 The captured operand registers need no reset value.

Configuration
REQ-026 Macro DOT_PRODUCT_SIGNED_EN defined: elements shall be two's complement, products shall be sign-extended to RW, and result shall be signed.
REQ-027 Macro DOT_PRODUCT_SIGNED_EN undefined: elements shall be unsigned and zero-extended; this is the default build.

Structure
REQ-028 Package dot_product_pkg shall hold the FSM state enum (IDLE, ACC) and the RW width-computation constant/function.
REQ-029 One sub-module, dot_mac_step, shall be used: combinational RW-bit multiply-add (acc + a*b), with signedness selected by the same macro.
REQ-030 The total implementation shall be 120-400 lines of RTL.

Verification (DW=8, K=4)
REQ-031 a={1,2,3,4}, b={5,6,7,8}, start pulse at edge 0 -> done high after edge 4, result=70, busy high for 4 cycles.
REQ-032 Unsigned build: all elements 0xFF -> result=260100 (18'h3F804), with no overflow.
REQ-033 DOT_PRODUCT_SIGNED_EN build: a all 0xFF (-1), b all 0x01 -> result=18'h3FFFC (-4).
REQ-034 start held high continuously with alternating operand sets -> done every 5 cycles, each result correct, and starts issued while busy have no effect.
REQ-035 reset asserted at edge 2 of an operation -> no done pulse, result=0, busy=0; a new start then computes a correct result.
REQ-036 a_vec/b_vec changed to all zeros one cycle after start -> result still equals the dot product of the captured operands (70 for the REQ-031 vectors).
